// File: rtl/pack_pkg.sv
// Shared definitions for the byte-to-halfword packer.
//   pack_state_e     : packer FSM state (no byte held / first byte held)
//   PACK_PAD_DEFAULT : default fill byte for the empty half of a flushed odd word
//   PACK_WORD_W      : output word width
package pack_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } pack_state_e;

    localparam logic [7:0] PACK_PAD_DEFAULT = 8'h00;
    localparam int unsigned PACK_WORD_W = 16;

    // Places the first and second byte of a pair into the word lanes.
    function automatic logic [PACK_WORD_W-1:0] pack_lanes(input logic       msb_first,
                                                          input logic [7:0] first_b,
                                                          input logic [7:0] second_b);
        return msb_first ? {first_b, second_b} : {second_b, first_b};
    endfunction

endpackage

// File: rtl/pack8_to16.sv
// Byte-to-halfword packer. Accepts bytes on a valid/ready handshake, pairs them
// into 16-bit words, and emits words on a second valid/ready handshake. A byte
// with in_last set while no byte is held is flushed as a padded word.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_byte/in_valid/in_last/in_ready : byte input stream
//   out_word/out_valid/out_ready/out_pad/out_last : word output stream
//   word_cnt              : words consumed since reset, wraps modulo 2^16
module pack8_to16
    import pack_pkg::*;
#(
    parameter bit         MSB_FIRST = 1'b1,
    parameter logic [7:0] PAD_BYTE  = PACK_PAD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_byte,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [PACK_WORD_W-1:0] out_word,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_pad,
    output logic                   out_last,
    output logic [15:0]            word_cnt
);

    pack_state_e            state_q, state_d;
    logic [7:0]             hold_q, hold_d;
    logic [PACK_WORD_W-1:0] out_word_q, out_word_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_pad_q, out_pad_d;
    logic                   out_last_q, out_last_d;
    logic [15:0]            word_cnt_q, word_cnt_d;

    logic accept;
    logic consume;

    // Output register can take a new word if empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q;
        out_pad_d   = out_pad_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;

        if (consume) begin
            out_valid_d = 1'b0;
            word_cnt_d  = word_cnt_q + 16'd1;
        end

        // A load in the same cycle as a consume overrides the clear above.
        if (accept) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_last) begin
                        out_word_d  = pack_lanes(MSB_FIRST, in_byte, PAD_BYTE);
                        out_pad_d   = 1'b1;
                        out_last_d  = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        hold_d  = in_byte;
                        state_d = ST_HALF;
                    end
                end
                ST_HALF: begin
                    out_word_d  = pack_lanes(MSB_FIRST, hold_q, in_byte);
                    out_pad_d   = 1'b0;
                    out_last_d  = in_last;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'h00;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            out_pad_q   <= 1'b0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            out_pad_q   <= out_pad_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

    assign out_word  = out_word_q;
    assign out_valid = out_valid_q;
    assign out_pad   = out_pad_q;
    assign out_last  = out_last_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_pack8_to16.sv
module tb_pack8_to16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        m_in_ready, m_out_valid, m_out_pad, m_out_last;
    logic [15:0] m_out_word, m_word_cnt;
    logic        l_in_ready, l_out_valid, l_out_pad, l_out_last;
    logic [15:0] l_out_word, l_word_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] word;
        logic        pad;
        logic        last;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    pack8_to16 #(.MSB_FIRST(1'b1), .PAD_BYTE(8'h00)) dut_m (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (m_in_ready),
        .out_word  (m_out_word),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .out_pad   (m_out_pad),
        .out_last  (m_out_last),
        .word_cnt  (m_word_cnt)
    );

    pack8_to16 #(.MSB_FIRST(1'b0), .PAD_BYTE(8'h00)) dut_l (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (l_in_ready),
        .out_word  (l_out_word),
        .out_valid (l_out_valid),
        .out_ready (out_ready),
        .out_pad   (l_out_pad),
        .out_last  (l_out_last),
        .word_cnt  (l_word_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: compares every word consumed by the MSB-first
    // instance; the LSB-first instance must present the byte-swapped word.
    always @(negedge clk) begin
        if (rst_n && m_out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %0h, required none", m_out_word);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_word", {16'h0, m_out_word}, {16'h0, e.word});
                check("out_pad", {31'h0, m_out_pad}, {31'h0, e.pad});
                check("out_last", {31'h0, m_out_last}, {31'h0, e.last});
                check("lsb_out_word", {16'h0, l_out_word}, {16'h0, e.word[7:0], e.word[15:8]});
                check("lsb_out_valid", {31'h0, l_out_valid}, 32'h1);
            end
        end
    end

    task automatic expect_word(input logic [15:0] w, input logic p, input logic l);
        exp_t e;
        e.word = w;
        e.pad  = p;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Called in the driver phase (#1 after posedge); returns in the same phase
    // after the byte has been accepted. waits = cycles spent offering it.
    task automatic send(input logic [7:0] b, input logic l, output int waits);
        logic ok;
        waits = 0;
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = l;
        do begin
            @(negedge clk);
            ok = m_in_ready;
            waits++;
            @(posedge clk);
            #1;
        end while (!ok && waits < 50);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %0h not accepted, required accept", b);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        rst_n     = 1'b0;
        in_byte   = 8'h00;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", {31'h0, m_in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, m_out_valid}, 32'h0);
        check("rst_out_word", {16'h0, m_out_word}, 32'h0);
        check("rst_word_cnt", {16'h0, m_word_cnt}, 32'h0);
        check("rst_pad_last", {30'h0, m_out_pad, m_out_last}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic pair, both lane orders
        expect_word(16'h1234, 1'b0, 1'b0);
        send(8'h12, 1'b0, w);
        send(8'h34, 1'b0, w);
        @(negedge clk);
        check("pair_valid", {31'h0, m_out_valid}, 32'h1);
        check("pair_word", {16'h0, m_out_word}, 32'h1234);
        check("pair_lsb_word", {16'h0, l_out_word}, 32'h3412);
        @(posedge clk);
        #1;
        idle(2);
        check("pair_word_cnt", {16'h0, m_word_cnt}, 32'h1);

        // Streaming ramp with a fresh counter
        do_reset(1);
        for (int i = 0; i < 10; i += 2) begin
            expect_word({i[7:0], i[7:0] + 8'd1}, 1'b0, 1'b0);
        end
        for (int i = 0; i < 10; i++) begin
            send(i[7:0], 1'b0, w);
            check("ramp_in_ready_waits", w, 32'd1);
        end
        idle(3);
        check("ramp_word_cnt", {16'h0, m_word_cnt}, 32'd5);

        // Backpressure
        out_ready = 1'b0;
        expect_word(16'h1234, 1'b0, 1'b0);
        expect_word(16'h5678, 1'b0, 1'b0);
        send(8'h12, 1'b0, w);
        send(8'h34, 1'b0, w);
        in_valid = 1'b1;
        in_byte  = 8'h56;
        in_last  = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", {31'h0, m_in_ready}, 32'h0);
            check("bp_out_word", {16'h0, m_out_word}, 32'h1234);
            check("bp_out_valid", {31'h0, m_out_valid}, 32'h1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(8'h56, 1'b0, w);
        send(8'h78, 1'b0, w);
        idle(3);
        check("bp_word_cnt", {16'h0, m_word_cnt}, 32'd7);

        // Odd flush then a full last word
        expect_word(16'hAB00, 1'b1, 1'b1);
        expect_word(16'hCDEF, 1'b0, 1'b1);
        send(8'hAB, 1'b1, w);
        send(8'hCD, 1'b0, w);
        send(8'hEF, 1'b1, w);
        idle(3);

        // Reset mid-pair discards the held byte
        send(8'h11, 1'b0, w);
        idle(1);
        do_reset(2);
        check("rst_mid_queue_empty", exp_q.size(), 32'd0);
        check("rst_mid_word_cnt", {16'h0, m_word_cnt}, 32'h0);
        expect_word(16'h2233, 1'b0, 1'b0);
        send(8'h22, 1'b0, w);
        send(8'h33, 1'b0, w);
        idle(3);

        // Counter wrap
        force dut_m.word_cnt_q = 16'hFFFF;
        #1;
        release dut_m.word_cnt_q;
        @(negedge clk);
        check("wrap_pre", {16'h0, m_word_cnt}, 32'hFFFF);
        @(posedge clk);
        #1;
        expect_word(16'h0100, 1'b1, 1'b1);
        send(8'h01, 1'b1, w);
        idle(3);
        check("wrap_post", {16'h0, m_word_cnt}, 32'h0);

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, required finish");
        $display("CHECKS %0d ERRORS %0d", checks + 1, errors + 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pack8_to16.md
# pack8_to16

Byte-to-halfword packer: accepts a stream of 8-bit bytes on a valid/ready handshake and emits 16-bit words on a second valid/ready handshake. It sits downstream of the 16-to-8 narrowing path and restores 16-bit samples from a byte stream. An odd trailing byte can be flushed as a padded word on `in_last`.

## Interface
- `MSB_FIRST`, default 1: 1 = first byte of a pair goes to `out_word[15:8]`; 0 = first byte goes to `out_word[7:0]`.
- `PAD_BYTE`, default 8'h00: fill value for the missing half of a flushed odd word.
- `clk`  in  1  single clock, all logic rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_byte`  in  8  input byte.
- `in_valid`  in  1  `in_byte` and `in_last` are valid.
- `in_last`  in  1  this byte ends a packet; flush any partial word.
- `in_ready`  out  1  packer can accept a byte this cycle.
- `out_word`  out  16  packed word.
- `out_valid`  out  1  `out_word`, `out_pad` and `out_last` are valid.
- `out_ready`  in  1  consumer takes the word this cycle.
- `out_pad`  out  1  the word holds only one real byte; the other half is `PAD_BYTE`.
- `out_last`  out  1  the word ends a packet.
- `word_cnt`  out  16  count of words consumed since reset; wraps modulo 2^16.

## Operation
- Byte handshake: a byte is accepted when `in_valid && in_ready`.
- Word handshake: a word is consumed when `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. This is combinational from state and `out_ready`; it never depends on `in_valid`.
- States: IDLE (no byte held), HALF (first byte held in `hold_q`). `out_valid` is a separate output register, independent of the IDLE/HALF state.
- IDLE, accept, `in_last=0`:
  - Store the byte in `hold_q`; go to HALF.
- IDLE, accept, `in_last=1`:
  - Load the output as {byte, `PAD_BYTE`}, or {`PAD_BYTE`, byte} when `MSB_FIRST=0`.
  - Set `out_pad=1`, `out_last=1`, `out_valid=1`; stay in IDLE.
- HALF, accept:
  - Load the output as {`hold_q`, byte} when `MSB_FIRST=1`, else {byte, `hold_q`}.
  - Set `out_pad=0`, `out_last=in_last`, `out_valid=1`; go to IDLE.
- Consume without a new load: clear `out_valid`. `out_word`, `out_pad` and `out_last` keep their values.
- Consume and load in the same cycle: the new word replaces the old one and `out_valid` stays 1. This gives no bubble and one byte per cycle of sustained throughput.
- `word_cnt` increments by 1 on every consume; 16'hFFFF wraps to 0.
- `in_last` is ignored unless a byte is actually accepted.
- While `out_valid && !out_ready`:
  - `out_word`, `out_pad` and `out_last` are stable.
  - `in_ready=0`, so no byte is lost.

## Timing
- Reset values: `out_word=0`, `out_valid=0`, `out_pad=0`, `out_last=0`, `word_cnt=0`, `hold_q=0`, state IDLE. `in_ready` therefore reads 1 during reset.
- Latency: the word is valid the cycle after the second byte (or a flushing `in_last` byte) is accepted.
- Throughput: one byte per clock, one word per two clocks, with `out_ready` held high.
- Reset asserted mid-operation: any held byte and any pending word are discarded immediately, with no output. The first byte accepted after release starts a new pair.
- Reset release: the first accept can occur on the first rising edge after `rst_n` goes high.
- Empty packet: `in_last` is only meaningful with an accepted byte, so a zero-byte flush does not exist.

## Structure
- Shared package `pack_pkg`:
  - state enum `{ST_IDLE, ST_HALF}`.
  - constant `PACK_PAD_DEFAULT = 8'h00`.
  - constant `PACK_WORD_W = 16`.
- No sub-module. The FSM, hold register, output register and counter form one module. The lane placement is a `MSB_FIRST`-selected concatenation.

## Test plan
- `MSB_FIRST=1`, `out_ready=1`, bytes 8'h12, 8'h34 back-to-back:
  - `out_word=16'h1234`, `out_pad=0`, `out_last=0` one cycle after 8'h34.
  - `word_cnt=1` after the consume.
- `MSB_FIRST=0`, same bytes: `out_word=16'h3412`.
- Streaming ramp of bytes 0x00..0x09 with `out_ready=1`:
  - Words 0x0001, 0x0203, 0x0405, 0x0607, 0x0809 on alternate cycles.
  - `in_ready` constantly 1; `word_cnt=5` at the end.
- Backpressure: after word 0x1234 is formed, hold `out_ready=0` for 5 cycles while `in_valid=1` with byte 8'h56.
  - `in_ready=0` and `out_word` stable throughout.
  - Then raise `out_ready` with bytes 8'h56, 8'h78: the next word is 0x5678 and no byte is dropped.
- Odd flush: byte 8'hAB with `in_last=1` from IDLE.
  - `out_word=16'hAB00`, `out_pad=1`, `out_last=1`.
  - Then bytes 8'hCD, 8'hEF (`in_last` on 8'hEF) give 0xCDEF with `out_pad=0`, `out_last=1`.
- Reset and wrap:
  - Send 8'h11, assert `rst_n=0` for 2 cycles, release, then send 8'h22, 8'h33: the word is 0x2233, with no trace of 0x11.
  - Force `word_cnt` to 16'hFFFF, then consume one word: `word_cnt` reads 0.
